us_lite_capture: RTL and testbench
==================================

# us_lite_capture

Register bank and sample-capture buffer on the Xillybus-Lite user port of the ultrasound system. Directly downstream of the `xillybus_lite_0_user_*` pins. The ARM CPU uses it to arm an acquisition, wait for a hardware trigger and collect a fixed number of ADC samples into an on-chip FIFO. The CPU then drains the samples through a pop-on-read data register, with an interrupt on threshold or completion.

## Interface
Parameters:
- `DEPTH`, 1024: FIFO depth in samples. Must be a power of two.
- `SAMPLE_W`, 16: ADC sample width, at most 32.

Ports:
- `bus_clk` in, 1: single clock. The Lite `user_clk_pin` drives it.
- `bus_rst_n` in, 1: reset, asynchronous and active-low.
- `user_wren` in, 1: one-cycle write strobe.
- `user_wstrb` in, 4: byte enables for `user_wren`.
- `user_rden` in, 1: one-cycle read strobe.
- `user_addr` in, 32: byte address. Only `[4:2]` is decoded.
- `user_wr_data` in, 32: write data.
- `user_rd_data` out, 32: read data.
- `user_irq` out, 1: level interrupt to the Lite core.
- `adc_valid` in, 1: sample qualifier.
- `adc_data` in, `SAMPLE_W`: ADC sample.
- `trig` in, 1: acquisition trigger, already synchronous to `bus_clk`.

## Operation
Register map, word index is `addr[4:2]`:
- 0 CTRL, RW.
  - bit0 `arm`.
  - bit1 `irq_en`.
  - bit2 `clear`: write-1, self-clearing, reads 0.
- 1 STATUS, RO.
  - bit0 `busy`: ARMED or CAPTURE.
  - bit1 `done`: sticky.
  - bit2 `ovf`: sticky.
  - bits `[26:16]` FIFO level, 0..DEPTH.
- 2 NSAMP, RW, bits `[15:0]`: samples to capture. 0 is treated as 1.
- 3 THRESH, RW, bits `[15:0]`: IRQ level threshold.
- 4 DATA, RO.
  - Read returns the zero-extended FIFO head and pops it.
  - Read while empty returns 0 and does not pop.
- 5 IRQ_STAT, W1C.
  - bit0 `thr`: set on the cycle level becomes ≥ THRESH while THRESH ≠ 0.
  - bit1 `cmp`: set on entry to DONE.
- 6, 7: read 0, writes ignored.

Register write rules:
- Writes honour `user_wstrb` per byte.
- `clear` and W1C bits act only if byte 0 is strobed.

`user_irq` = `irq_en & (thr | cmp)`.

Capture FSM, package enum `cap_state_t`:
- IDLE → ARMED: when `arm` is written 1. The sample counter loads NSAMP.
- ARMED → CAPTURE: on `trig`=1.
- ARMED or CAPTURE → IDLE: when `arm` is written 0. No `done` is set.
- CAPTURE, each `adc_valid`:
  - Push `adc_data`.
  - Decrement the counter.
  - If the FIFO is full, drop the sample, set `ovf`, and still decrement.
- CAPTURE → DONE: on the cycle the counter reaches 0. Counter width is 17 bits.
- DONE → IDLE, next cycle:
  - Set `done` and `cmp`.
  - Hardware clears `arm`.

Clearing rules:
- `done` and `ovf` clear when `arm` is written 1.
- `clear` empties the FIFO, clears `ovf`, `done` and IRQ_STAT, and forces the FSM to IDLE. It has priority over every simultaneous event.

## Timing
Reset values:
- All outputs 0. `user_rd_data` = 0, `user_irq` = 0.
- FSM in IDLE.
- All registers 0.
- FIFO empty.

Latencies:
- Read: `user_rd_data` is registered and valid on the cycle after `user_rden`. It holds until the next read.
- Write: takes effect on the cycle after `user_wren`.
- `trig` → first accepted sample: the sample with `adc_valid` on the cycle after `trig` is the first accepted.
- Push → level visible in STATUS: 1 cycle.
- FIFO read data: comes from a registered head, so a DATA pop returns the word at the head when `user_rden` was sampled.

Simultaneous events:
- Push and pop in the same cycle: level unchanged, both succeed. Valid when full: pop frees a slot, push accepted. Valid when empty: pop returns 0, push accepted.
- Hardware sets a W1C bit in the same cycle the CPU writes 1 to it: the set wins.
- Level and wrap-around: pointers are `log2(DEPTH)` bits and wrap. Level is tracked as a separate counter, which gives full = DEPTH and empty = 0.

Reset mid-capture: everything is lost asynchronously and the block returns to the reset values.

## Structure
- Package `us_lite_pkg` holds:
  - Register index constants `REG_CTRL` … `REG_IRQ`.
  - CTRL, STATUS and IRQ bit-position constants.
  - `cap_state_t`.
- Sub-module `us_sync_fifo`, parameters `DEPTH` and `W`.
  - Ports: push, pop, din, dout, level, full, empty, clr.
  - It is single-clock with a registered output.
- The top level holds register decode, the FSM, the sample counter and the IRQ logic.

## Test plan
- Reset, then read every register → all 0, `user_irq`=0, `rd_data` valid 1 cycle after `rden`.
- NSAMP=4, arm, pulse `trig`, then drive 6 valid samples 0x11..0x16 → level 4, `done`=1, `cmp`=1. Four DATA reads return 0x11..0x14. The fifth read returns 0 with level still 0.
- NSAMP=1030 with DEPTH=1024 and no reads during capture → `ovf`=1, level 1024, `done`=1. The first DATA read returns the first sample.
- THRESH=3, `irq_en`=1, capture 5 samples → `user_irq` rises the cycle after the third push. Writing IRQ_STAT=0x3 drops the IRQ. A write with `wstrb`=4'b0010 does not drop it.
- Write `arm`=0 mid-capture after 2 of 8 samples → FSM returns to IDLE, `done`=0, level 2. `clear` → level 0.
- Full FIFO with a DATA read and `adc_valid` in the same cycle → level stays at DEPTH and `ovf` stays 0.

Source files
------------

// File: rtl/us_lite_pkg.sv
// us_lite_pkg: register indices, bit positions and the capture state type
// shared by the Xillybus-Lite capture block and its bench.
package us_lite_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_NSAMP  = 3'd2;
    localparam logic [2:0] REG_THRESH = 3'd3;
    localparam logic [2:0] REG_DATA   = 3'd4;
    localparam logic [2:0] REG_IRQ    = 3'd5;

    localparam int CTRL_ARM    = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_LEVEL_LSB = 16;

    localparam int IRQ_THR = 0;
    localparam int IRQ_CMP = 1;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/us_sync_fifo.sv
// us_sync_fifo: single-clock sample FIFO with a registered head word.
// The level is a separate counter so full (DEPTH) and empty (0) are
// unambiguous while the pointers simply wrap.
module us_sync_fifo #(
    parameter int DEPTH = 1024,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop) & ~clr;

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, level and the registered head word that always mirrors mem[rd_ptr].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LW'(1);
            end
            if (do_push && (empty || (do_pop && level == LW'(1)))) begin
                dout <= din;
            end else if (do_pop && level > LW'(1)) begin
                dout <= mem[rd_ptr + AW'(1)];
            end else if (do_pop) begin
                dout <= '0;
            end
        end
    end

endmodule

// File: rtl/us_lite_capture.sv
// us_lite_capture: Xillybus-Lite register bank, trigger-driven capture FSM
// and pop-on-read sample FIFO with threshold/completion interrupt.
module us_lite_capture
    import us_lite_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int SAMPLE_W = 16
) (
    input  logic                bus_clk,
    input  logic                bus_rst_n,
    input  logic                user_wren,
    input  logic [3:0]          user_wstrb,
    input  logic                user_rden,
    input  logic [31:0]         user_addr,
    input  logic [31:0]         user_wr_data,
    output logic [31:0]         user_rd_data,
    output logic                user_irq,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                trig
);

    localparam int LW = $clog2(DEPTH) + 1;

    cap_state_t          state;
    logic [16:0]         count;
    logic                arm;
    logic                irq_en;
    logic                done;
    logic                ovf;
    logic                irq_thr;
    logic                irq_cmp;
    logic [15:0]         nsamp;
    logic [15:0]         thresh;
    logic [2:0]          idx;
    logic                wr_ctrl;
    logic                wr_irq;
    logic                clear_req;
    logic                arm_set;
    logic                arm_drop;
    logic                rd_pop;
    logic                sample_hit;
    logic                push_ok;
    logic                drop;
    logic                done_entry;
    logic                thr_cross;
    logic [LW-1:0]       level;
    logic [LW-1:0]       level_nxt;
    logic [SAMPLE_W-1:0] head;
    logic                full;
    logic                empty;
    logic [31:0]         rd_word;
    logic                unused_bits;

    assign idx        = user_addr[4:2];
    assign wr_ctrl    = user_wren && (idx == REG_CTRL) && user_wstrb[0];
    assign wr_irq     = user_wren && (idx == REG_IRQ) && user_wstrb[0];
    assign clear_req  = wr_ctrl && user_wr_data[CTRL_CLEAR];
    assign arm_set    = wr_ctrl && user_wr_data[CTRL_ARM];
    assign arm_drop   = wr_ctrl && !user_wr_data[CTRL_ARM];
    assign rd_pop     = user_rden && (idx == REG_DATA) && !empty && !clear_req;
    assign sample_hit = (state == CAP_CAPTURE) && adc_valid && !arm_drop && !clear_req;
    assign push_ok    = sample_hit && (!full || rd_pop);
    assign drop       = sample_hit && full && !rd_pop;
    assign done_entry = sample_hit && (count == 17'd1);
    assign level_nxt  = level + LW'(push_ok) - LW'(rd_pop);
    assign thr_cross  = (thresh != 16'd0) && (32'(level_nxt) >= 32'(thresh))
                        && (32'(level) < 32'(thresh));
    assign user_irq   = irq_en & (irq_thr | irq_cmp);
    assign unused_bits = ^{user_addr[31:5], user_addr[1:0], user_wstrb[3:2], user_wr_data[31:16]};

    us_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (SAMPLE_W)
    ) u_fifo (
        .clk   (bus_clk),
        .rst_n (bus_rst_n),
        .clr   (clear_req),
        .push  (push_ok),
        .pop   (rd_pop),
        .din   (adc_data),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Capture FSM with sample counter, arm bit and sticky done/ovf flags.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state <= CAP_IDLE;
            count <= '0;
            arm   <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else if (clear_req) begin
            state <= CAP_IDLE;
            arm   <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                arm <= user_wr_data[CTRL_ARM];
            end
            if (arm_set) begin
                done <= 1'b0;
                ovf  <= 1'b0;
            end
            case (state)
                CAP_IDLE: begin
                    if (arm_set) begin
                        state <= CAP_ARMED;
                        count <= (nsamp == 16'd0) ? 17'd1 : {1'b0, nsamp};
                    end
                end
                CAP_ARMED: begin
                    if (arm_drop) begin
                        state <= CAP_IDLE;
                    end else if (trig) begin
                        state <= CAP_CAPTURE;
                    end
                end
                CAP_CAPTURE: begin
                    if (arm_drop) begin
                        state <= CAP_IDLE;
                    end else if (sample_hit) begin
                        count <= count - 17'd1;
                        if (drop) begin
                            ovf <= 1'b1;
                        end
                        if (done_entry) begin
                            state <= CAP_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                CAP_DONE: begin
                    state <= CAP_IDLE;
                    arm   <= 1'b0;
                end
                default: state <= CAP_IDLE;
            endcase
        end
    end

    // Plain RW configuration registers and the W1C interrupt status bits.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            irq_en  <= 1'b0;
            nsamp   <= '0;
            thresh  <= '0;
            irq_thr <= 1'b0;
            irq_cmp <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en <= user_wr_data[CTRL_IRQ_EN];
            end
            if (user_wren && idx == REG_NSAMP) begin
                if (user_wstrb[0]) nsamp[7:0]  <= user_wr_data[7:0];
                if (user_wstrb[1]) nsamp[15:8] <= user_wr_data[15:8];
            end
            if (user_wren && idx == REG_THRESH) begin
                if (user_wstrb[0]) thresh[7:0]  <= user_wr_data[7:0];
                if (user_wstrb[1]) thresh[15:8] <= user_wr_data[15:8];
            end
            if (clear_req) begin
                irq_thr <= 1'b0;
                irq_cmp <= 1'b0;
            end else begin
                irq_thr <= (irq_thr & ~(wr_irq & user_wr_data[IRQ_THR])) | thr_cross;
                irq_cmp <= (irq_cmp & ~(wr_irq & user_wr_data[IRQ_CMP])) | done_entry;
            end
        end
    end

    // Read mux for the word selected by the current address.
    always_comb begin
        rd_word = '0;
        case (idx)
            REG_CTRL: begin
                rd_word[CTRL_ARM]    = arm;
                rd_word[CTRL_IRQ_EN] = irq_en;
            end
            REG_STATUS: begin
                rd_word[STAT_BUSY] = (state == CAP_ARMED) || (state == CAP_CAPTURE);
                rd_word[STAT_DONE] = done;
                rd_word[STAT_OVF]  = ovf;
                rd_word[STAT_LEVEL_LSB +: LW] = level;
            end
            REG_NSAMP:  rd_word[15:0] = nsamp;
            REG_THRESH: rd_word[15:0] = thresh;
            REG_DATA: begin
                if (!empty) begin
                    rd_word[SAMPLE_W-1:0] = head;
                end
            end
            REG_IRQ: begin
                rd_word[IRQ_THR] = irq_thr;
                rd_word[IRQ_CMP] = irq_cmp;
            end
            default: rd_word = '0;
        endcase
    end

    // Registered read data, held until the next read strobe.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            user_rd_data <= '0;
        end else if (user_rden) begin
            user_rd_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_us_lite_capture.sv
// tb_us_lite_capture: scenario-based bench for us_lite_capture with a
// queue model of the capture FIFO and randomized sample data.
`timescale 1ns/1ps
module tb_us_lite_capture;
    import us_lite_pkg::*;

    localparam int DEPTH    = 1024;
    localparam int SAMPLE_W = 16;

    logic                bus_clk      = 1'b0;
    logic                bus_rst_n    = 1'b0;
    logic                user_wren    = 1'b0;
    logic [3:0]          user_wstrb   = 4'h0;
    logic                user_rden    = 1'b0;
    logic [31:0]         user_addr    = 32'h0;
    logic [31:0]         user_wr_data = 32'h0;
    logic [31:0]         user_rd_data;
    logic                user_irq;
    logic                adc_valid    = 1'b0;
    logic [SAMPLE_W-1:0] adc_data     = '0;
    logic                trig         = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [15:0] model_q[$];
    bit model_ovf;

    us_lite_capture #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .bus_clk      (bus_clk),
        .bus_rst_n    (bus_rst_n),
        .user_wren    (user_wren),
        .user_wstrb   (user_wstrb),
        .user_rden    (user_rden),
        .user_addr    (user_addr),
        .user_wr_data (user_wr_data),
        .user_rd_data (user_rd_data),
        .user_irq     (user_irq),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .trig         (trig)
    );

    always #5 bus_clk = ~bus_clk;

    function automatic logic [31:0] exp_status(input bit busy, input bit done, input bit ovf, input int lvl);
        logic [31:0] v;
        v = 32'(lvl) << 16;
        v[0] = busy;
        v[1] = done;
        v[2] = ovf;
        return v;
    endfunction

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] strb);
        user_addr    = {27'd0, idx, 2'b00};
        user_wr_data = data;
        user_wstrb   = strb;
        user_wren    = 1'b1;
        tick();
        user_wren  = 1'b0;
        user_wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [2:0] idx, output logic [31:0] data);
        user_addr = {27'd0, idx, 2'b00};
        user_rden = 1'b1;
        tick();
        user_rden = 1'b0;
        data = user_rd_data;
    endtask

    task automatic model_push(input logic [15:0] d);
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else model_ovf = 1'b1;
    endtask

    task automatic pulse_trig();
        trig      = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 16'hDEAD;
        tick();
        trig      = 1'b0;
        adc_valid = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        int sent;
        sent = 0;
        while (sent < n) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                adc_valid = 1'b0;
            end else begin
                adc_valid = 1'b1;
                adc_data  = 16'($urandom);
                model_push(adc_data);
                sent++;
            end
            tick();
        end
        adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        bus_rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (user_irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_irq: got %b expected 0", user_irq);
        end
        checks++;
        if (user_rd_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_rd_data: got %h expected 0", user_rd_data);
        end
        bus_rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), rd);
            checks++;
            if (rd !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_reg%0d: got %h expected 0", i, rd);
            end
        end
        bus_write(REG_NSAMP, 32'h0000_1234, 4'hF);
        user_addr = {27'd0, REG_NSAMP, 2'b00};
        user_rden = 1'b1;
        @(negedge bus_clk);
        checks++;
        if (user_rd_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rd_latency_early: got %h expected 0", user_rd_data);
        end
        tick();
        user_rden = 1'b0;
        checks++;
        if (user_rd_data !== 32'h0000_1234) begin
            errors++;
            $display("[TB] FAIL rd_latency: got %h expected 00001234", user_rd_data);
        end
        repeat (2) tick();
        checks++;
        if (user_rd_data !== 32'h0000_1234) begin
            errors++;
            $display("[TB] FAIL rd_hold: got %h expected 00001234", user_rd_data);
        end
        bus_write(REG_NSAMP, 32'h0, 4'hF);
    endtask

    task automatic test_basic_capture();
        logic [31:0] rd;
        model_q.delete();
        model_ovf = 1'b0;
        bus_write(REG_NSAMP, 32'd4, 4'hF);
        bus_write(REG_CTRL, 32'h1, 4'hF);
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== exp_status(1, 0, 0, 0)) begin
            errors++;
            $display("[TB] FAIL armed_status: got %h expected %h", rd, exp_status(1, 0, 0, 0));
        end
        pulse_trig();
        for (int i = 0; i < 6; i++) begin
            adc_valid = 1'b1;
            adc_data  = 16'(32'h11 + i);
            if (i < 4) model_push(adc_data);
            tick();
        end
        adc_valid = 1'b0;
        tick();
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== exp_status(0, 1, 0, model_q.size())) begin
            errors++;
            $display("[TB] FAIL basic_status: got %h expected %h", rd, exp_status(0, 1, 0, model_q.size()));
        end
        bus_read(REG_IRQ, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("[TB] FAIL basic_irq_stat: got %h expected 2", rd);
        end
        bus_read(REG_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL basic_arm_cleared: got %h expected 0", rd);
        end
        for (int i = 0; i < 5; i++) begin
            logic [31:0] exp;
            exp = (model_q.size() > 0) ? {16'd0, model_q.pop_front()} : 32'd0;
            bus_read(REG_DATA, rd);
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("[TB] FAIL basic_data%0d: got %h expected %h", i, rd, exp);
            end
        end
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== exp_status(0, 1, 0, 0)) begin
            errors++;
            $display("[TB] FAIL basic_drained: got %h expected %h", rd, exp_status(0, 1, 0, 0));
        end
        bus_write(REG_IRQ, 32'h3, 4'hF);
    endtask

    task automatic test_random_capture();
        logic [31:0] rd;
        for (int it = 0; it < 3; it++) begin
            int nsamp;
            int n_eff;
            nsamp = (it == 0) ? 0 : $urandom_range(2, 40);
            n_eff = (nsamp == 0) ? 1 : nsamp;
            model_q.delete();
            bus_write(REG_NSAMP, 32'(nsamp), 4'hF);
            bus_write(REG_CTRL, 32'h1, 4'hF);
            bus_read(REG_CTRL, rd);
            checks++;
            if (rd !== 32'h1) begin
                errors++;
                $display("[TB] FAIL rand%0d_arm_read: got %h expected 1", it, rd);
            end
            trig = 1'b1;
            tick();
            trig = 1'b0;
            user_addr = {27'd0, REG_DATA, 2'b00};
            user_rden = 1'b1;
            adc_valid = 1'b1;
            adc_data  = 16'($urandom);
            model_push(adc_data);
            tick();
            user_rden = 1'b0;
            adc_valid = 1'b0;
            checks++;
            if (user_rd_data !== 32'd0) begin
                errors++;
                $display("[TB] FAIL rand%0d_empty_pop: got %h expected 0", it, user_rd_data);
            end
            feed(n_eff - 1, 1'b1);
            adc_valid = 1'b1;
            repeat (3) begin
                adc_data = 16'($urandom);
                tick();
            end
            adc_valid = 1'b0;
            bus_read(REG_STATUS, rd);
            checks++;
            if (rd !== exp_status(0, 1, 0, model_q.size())) begin
                errors++;
                $display("[TB] FAIL rand%0d_status: got %h expected %h", it, rd, exp_status(0, 1, 0, model_q.size()));
            end
            bus_read(REG_IRQ, rd);
            checks++;
            if (rd !== 32'h2) begin
                errors++;
                $display("[TB] FAIL rand%0d_irq_stat: got %h expected 2", it, rd);
            end
            bus_write(REG_IRQ, 32'h3, 4'hF);
            while (model_q.size() > 0) begin
                logic [31:0] exp;
                exp = {16'd0, model_q.pop_front()};
                bus_read(REG_DATA, rd);
                checks++;
                if (rd !== exp) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_data: got %h expected %h", it, rd, exp);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [31:0] exp;
        model_q.delete();
        model_ovf = 1'b0;
        bus_write(REG_NSAMP, 32'd1030, 4'hF);
        bus_write(REG_CTRL, 32'h1, 4'hF);
        pulse_trig();
        feed(1030, 1'b0);
        tick();
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== exp_status(0, 1, model_ovf, model_q.size())) begin
            errors++;
            $display("[TB] FAIL ovf_status: got %h expected %h", rd, exp_status(0, 1, model_ovf, model_q.size()));
        end
        exp = {16'd0, model_q.pop_front()};
        bus_read(REG_DATA, rd);
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("[TB] FAIL ovf_first_data: got %h expected %h", rd, exp);
        end
        bus_write(REG_CTRL, 32'h4, 4'hF);
        model_q.delete();
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== exp_status(0, 0, 0, 0)) begin
            errors++;
            $display("[TB] FAIL clear_status: got %h expected 0", rd);
        end
        bus_read(REG_IRQ, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL clear_irq_stat: got %h expected 0", rd);
        end
    endtask

    task automatic test_threshold_irq();
        logic [31:0] rd;
        model_q.delete();
        bus_write(REG_THRESH, 32'd3, 4'hF);
        bus_write(REG_NSAMP, 32'd5, 4'hF);
        bus_write(REG_CTRL, 32'h3, 4'hF);
        pulse_trig();
        for (int k = 1; k <= 5; k++) begin
            logic exp_irq;
            adc_valid = 1'b1;
            adc_data  = 16'($urandom);
            model_push(adc_data);
            tick();
            exp_irq = (model_q.size() >= 3);
            checks++;
            if (user_irq !== exp_irq) begin
                errors++;
                $display("[TB] FAIL irq_after_push%0d: got %b expected %b", k, user_irq, exp_irq);
            end
        end
        adc_valid = 1'b0;
        tick();
        bus_read(REG_IRQ, rd);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("[TB] FAIL thr_irq_stat: got %h expected 3", rd);
        end
        bus_write(REG_IRQ, 32'h3, 4'b0010);
        checks++;
        if (user_irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_wstrb_byte1: got %b expected 1", user_irq);
        end
        bus_write(REG_IRQ, 32'h3, 4'hF);
        checks++;
        if (user_irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_w1c: got %b expected 0", user_irq);
        end
        while (model_q.size() > 0) begin
            logic [31:0] exp;
            exp = {16'd0, model_q.pop_front()};
            bus_read(REG_DATA, rd);
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("[TB] FAIL thr_data: got %h expected %h", rd, exp);
            end
        end
        bus_write(REG_THRESH, 32'd0, 4'hF);
        bus_write(REG_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        model_q.delete();
        bus_write(REG_NSAMP, 32'd8, 4'hF);
        bus_write(REG_CTRL, 32'h1, 4'hF);
        pulse_trig();
        feed(2, 1'b0);
        bus_write(REG_CTRL, 32'h0, 4'hF);
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== exp_status(0, 0, 0, model_q.size())) begin
            errors++;
            $display("[TB] FAIL abort_status: got %h expected %h", rd, exp_status(0, 0, 0, model_q.size()));
        end
        adc_valid = 1'b1;
        repeat (4) begin
            adc_data = 16'($urandom);
            tick();
        end
        adc_valid = 1'b0;
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== exp_status(0, 0, 0, model_q.size())) begin
            errors++;
            $display("[TB] FAIL abort_idle_samples: got %h expected %h", rd, exp_status(0, 0, 0, model_q.size()));
        end
        bus_read(REG_IRQ, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_no_cmp: got %h expected 0", rd);
        end
        bus_write(REG_CTRL, 32'h4, 4'hF);
        model_q.delete();
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== exp_status(0, 0, 0, 0)) begin
            errors++;
            $display("[TB] FAIL abort_clear: got %h expected 0", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] exp;
        int bad;
        model_q.delete();
        model_ovf = 1'b0;
        bus_write(REG_NSAMP, 32'd1025, 4'hF);
        bus_write(REG_CTRL, 32'h1, 4'hF);
        pulse_trig();
        feed(DEPTH, 1'b0);
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== exp_status(1, 0, 0, model_q.size())) begin
            errors++;
            $display("[TB] FAIL full_status: got %h expected %h", rd, exp_status(1, 0, 0, model_q.size()));
        end
        user_addr = {27'd0, REG_DATA, 2'b00};
        user_rden = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 16'($urandom);
        exp = {16'd0, model_q.pop_front()};
        model_q.push_back(adc_data);
        tick();
        user_rden = 1'b0;
        adc_valid = 1'b0;
        checks++;
        if (user_rd_data !== exp) begin
            errors++;
            $display("[TB] FAIL full_pop_data: got %h expected %h", user_rd_data, exp);
        end
        tick();
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== exp_status(0, 1, model_ovf, model_q.size())) begin
            errors++;
            $display("[TB] FAIL full_pop_push_status: got %h expected %h", rd, exp_status(0, 1, model_ovf, model_q.size()));
        end
        bad = 0;
        while (model_q.size() > 0) begin
            exp = {16'd0, model_q.pop_front()};
            bus_read(REG_DATA, rd);
            checks++;
            if (rd !== exp) begin
                errors++;
                bad++;
                if (bad <= 8) $display("[TB] FAIL wrap_data: got %h expected %h", rd, exp);
            end
        end
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== exp_status(0, 1, 0, 0)) begin
            errors++;
            $display("[TB] FAIL wrap_drained: got %h expected %h", rd, exp_status(0, 1, 0, 0));
        end
    endtask

    task automatic test_reset_mid_capture();
        logic [31:0] rd;
        model_q.delete();
        bus_write(REG_NSAMP, 32'd8, 4'hF);
        bus_write(REG_CTRL, 32'h3, 4'hF);
        bus_read(REG_CTRL, rd);
        pulse_trig();
        feed(3, 1'b1);
        bus_rst_n = 1'b0;
        #2;
        checks++;
        if (user_rd_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midreset_rd_data: got %h expected 0", user_rd_data);
        end
        tick();
        bus_rst_n = 1'b1;
        tick();
        model_q.delete();
        bus_read(REG_STATUS, rd);
        checks++;
        if (rd !== exp_status(0, 0, 0, 0)) begin
            errors++;
            $display("[TB] FAIL midreset_status: got %h expected 0", rd);
        end
        bus_read(REG_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_ctrl: got %h expected 0", rd);
        end
        bus_read(REG_NSAMP, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_nsamp: got %h expected 0", rd);
        end
    endtask

    // Sequence of scenarios followed by the summary line.
    initial begin
        test_reset();
        test_basic_capture();
        test_random_capture();
        test_overflow();
        test_threshold_irq();
        test_abort();
        test_back_to_back();
        test_reset_mid_capture();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time in case the design stalls the sequence.
    initial begin
        #2ms;
        errors++;
        checks++;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
